// File: rtl/blake2_msg_feeder.sv
// Host-side feeder for the blake2 core: cuts a host byte stream into zero-padded
// blocks, drives the core's byte-load port and gathers the streamed digest.
module blake2_msg_feeder #(
  parameter int W      = 32,
  parameter int BB     = 2*W,
  parameter int LEN_W  = 32,
  parameter int NN_MAX = 32
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [$clog2(W+1)-1:0]  nn_i,
  input  logic                    msg_v_i,
  input  logic [7:0]              msg_i,
  output logic                    msg_rdy_o,
  input  logic                    core_ready_i,
  output logic                    data_v_o,
  output logic [$clog2(BB)-1:0]   data_idx_o,
  output logic [7:0]              data_o,
  output logic                    block_first_o,
  output logic                    block_last_o,
  output logic [$clog2(W+1)-1:0]  kk_o,
  output logic [$clog2(W+1)-1:0]  nn_o,
  output logic [BB-1:0]           ll_o,
  input  logic                    hash_v_i,
  input  logic [7:0]              hash_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [8*NN_MAX-1:0]     digest_o
);

  // The core's block size in bytes equals BB numerically (64 for W=32, 128 for W=64).
  localparam int NW  = $clog2(W+1);
  localparam int IW  = $clog2(BB);
  localparam int CW  = LEN_W + 1;
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FEED = 2'd1,
    HASH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [NW-1:0]        nn_q, nn_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [NW-1:0]        rcnt_q, rcnt_d;
  logic                 blockFirst_q, blockFirst_d;
  logic                 blockLast_q, blockLast_d;
  logic [8*NN_MAX-1:0]  digest_q, digest_d;

  logic [CW-1:0] lenExt;
  logic [CW-1:0] padTot;
  logic [CW-1:0] cntNext;
  logic          feeding;
  logic          pad;
  logic          blockEnd;

  function automatic logic isLast(input logic [CW-1:0] blkStart, input logic [CW-1:0] len);
    return ({1'b0, blkStart} + CW1'(BB)) >= {1'b0, len};
  endfunction

  assign lenExt   = {1'b0, len_q};
  assign padTot   = (len_q == '0) ? CW'(BB) : ((lenExt + CW'(BB-1)) & ~CW'(BB-1));
  assign cntNext  = cnt_q + CW'(1);
  assign feeding  = (state_q == FEED);
  assign pad      = (cnt_q >= lenExt);
  assign blockEnd = &cnt_q[IW-1:0];

  // Handshake stays combinational so no byte slips out when the core drops ready.
  assign data_v_o   = feeding & core_ready_i & (pad | msg_v_i);
  assign msg_rdy_o  = feeding & core_ready_i & ~pad;
  assign data_o     = (feeding & ~pad) ? msg_i : 8'h00;
  assign data_idx_o = cnt_q[IW-1:0];

  assign block_first_o = blockFirst_q;
  assign block_last_o  = blockLast_q;
  assign kk_o          = '0;
  assign nn_o          = nn_q;
  assign ll_o          = BB'(len_q);
  assign busy_o        = (state_q != IDLE);
  assign done_o        = (state_q == DONE);
  assign digest_o      = digest_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    nn_d         = nn_q;
    cnt_d        = cnt_q;
    rcnt_d       = rcnt_q;
    blockFirst_d = blockFirst_q;
    blockLast_d  = blockLast_q;
    digest_d     = digest_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          len_d        = len_i;
          nn_d         = nn_i;
          cnt_d        = '0;
          rcnt_d       = '0;
          digest_d     = '0;
          blockFirst_d = 1'b1;
          blockLast_d  = isLast('0, {1'b0, len_i});
          state_d      = FEED;
        end
      end

      FEED: begin
        if (data_v_o) begin
          cnt_d = cntNext;
          if (blockEnd) begin
            if (cntNext == padTot) begin
              state_d = HASH;
            end else begin
              blockFirst_d = 1'b0;
              blockLast_d  = isLast(cntNext, lenExt);
            end
          end
        end
      end

      HASH: begin
        // rcnt_q == 0 marks the stale lead byte of the burst; byte j lands at rcnt_q == j+1.
        if (hash_v_i) begin
          for (int j = 0; j < NN_MAX; j++) begin
            if (rcnt_q == NW'(j + 1)) begin
              digest_d[8*j +: 8] = hash_i;
            end
          end
          if (rcnt_q == nn_q) begin
            state_d = DONE;
          end else begin
            rcnt_d = rcnt_q + NW'(1);
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      nn_q         <= '0;
      cnt_q        <= '0;
      rcnt_q       <= '0;
      blockFirst_q <= 1'b0;
      blockLast_q  <= 1'b0;
      digest_q     <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      nn_q         <= nn_d;
      cnt_q        <= cnt_d;
      rcnt_q       <= rcnt_d;
      blockFirst_q <= blockFirst_d;
      blockLast_q  <= blockLast_d;
      digest_q     <= digest_d;
    end
  end

endmodule

// File: doc/blake2_msg_feeder.md
# blake2_msg_feeder

Host-side driver for the `blake2` hashing core. It accepts a message as a byte stream from the host, along with a start command carrying the message length and digest length. It segments the message into 64-byte blocks, zero-pads the final block, and drives the core's byte-load interface (`data_v/idx/data`, `block_first/last`, `kk/nn/ll`). It then collects the digest bytes the core streams back on `h_v/h` and presents the digest as a parallel word with a done pulse.

## Interface
Parameters:
- `W`, 32, core word width. With W=32 the core runs BLAKE2s with 64-byte blocks.
- `BB`, `2*W`, core counter width in bits; also the width of `ll_o`.
- `LEN_W`, 32, width of the message-length input.
- `NN_MAX`, 32, maximum digest bytes; sets the width of `digest_o`.

Ports:
- `clk`  in  1  — the single clock.
- `nreset`  in  1  — reset, asynchronous and active-low.
- `start_i`  in  1  — one-cycle command; accepted only in IDLE.
- `len_i`  in  LEN_W  — message length in bytes; sampled on `start_i`.
- `nn_i`  in  $clog2(W+1)  — digest length, 1..NN_MAX; sampled on `start_i`.
- `msg_v_i`  in  1  — host message byte valid.
- `msg_i`  in  8  — host message byte.
- `msg_rdy_o`  out  1  — message byte consumed this cycle when `msg_v_i & msg_rdy_o`.
- `core_ready_i`  in  1  — from core `ready_v_o`.
- `data_v_o`  out  1  — to core `data_v_i`.
- `data_idx_o`  out  $clog2(BB)  — byte index within the block, 0..63.
- `data_o`  out  8  — byte to core.
- `block_first_o`, `block_last_o`  out  1 each  — block flags to core.
- `kk_o`  out  $clog2(W+1)  — key length; always 0 (keyed mode not supported).
- `nn_o`  out  $clog2(W+1)  — latched `nn_i`.
- `ll_o`  out  BB  — latched `len_i`, zero-extended.
- `hash_v_i`  in  1  — from core `h_v_o`.
- `hash_i`  in  8  — from core `h_o`.
- `busy_o`  out  1  — high in every state except IDLE.
- `done_o`  out  1  — one-cycle pulse when the digest is complete.
- `digest_o`  out  8*NN_MAX  — digest; byte 0 occupies bits [7:0]; held until the next start.

## Operation
States:
- **IDLE.** On `start_i`, latch `len_i` into `len_q` and `nn_i` into `nn_q`, clear the byte counter `cnt_q` (LEN_W+1 bits), clear `digest_o`, then go to FEED.
- **FEED.**
  - Padded total `tot = max(64, roundup64(len_q))`.
  - Byte `k = cnt_q` is a padding byte when `k >= len_q`.
  - `data_v_o = core_ready_i & (pad | msg_v_i)`.
  - `msg_rdy_o = core_ready_i & ~pad`.
  - `data_o = pad ? 8'h00 : msg_i`.
  - `data_idx_o = cnt_q[5:0]`.
  - On each `data_v_o`, `cnt_q` increments.
  - When byte 63 of the block with `cnt_q + 1 == tot` is sent, go to HASH.
- **Block flags.** Both are registered and constant for the whole block.
  - `block_first_o = (cnt_q[LEN_W:6] == 0)`.
  - `block_last_o = (block_start + 64 >= len_q)`, with `len_q == 0` giving first=last=1.
- **HASH.**
  - The core asserts `hash_v_i` for nn+1 consecutive cycles. The first byte of the burst is stale and is discarded.
  - Each following valid byte j (j = 0..nn_q-1) is written to `digest_o[8j+7:8j]`, using a byte counter `rcnt_q`.
  - After byte nn_q-1 is captured, go to DONE.
- **DONE.** Pulse `done_o` for one cycle, then go to IDLE.

Held values:
- `nn_o` and `ll_o` hold their latched values from FEED through the end of HASH. In IDLE they hold the last job's values.
- `kk_o` is tied to 0.

Other rules:
- `start_i` while `busy_o` is high is ignored.
- `msg_v_i` outside FEED is ignored and `msg_rdy_o` stays 0.
- The host supplies exactly `len_q` message bytes; extra bytes are never consumed.
- A host stall (`msg_v_i` low) mid-block holds all outputs. `data_v_o` stays low until the byte arrives.

## Timing
Reset values: state=IDLE; `cnt_q`=0, `rcnt_q`=0; all outputs 0 (including `digest_o`, `nn_o`, `ll_o`) except `kk_o`, which is constant 0.

Latencies and handshake:
- `start_i` to first possible `data_v_o`: 1 cycle.
- `data_v_o`, `data_o` and `msg_rdy_o` are combinational from `core_ready_i`, `msg_v_i` and registers. This guarantees no byte is issued in the cycle the core drops ready after byte 63.
- The last captured digest byte to `done_o`: 1 cycle. `busy_o` deasserts in the cycle after `done_o`.

Boundary conditions:
- `len` an exact multiple of 64 (nonzero): no padding block is added.
- `len = 0`: one all-zero block with first=last=1 and `ll_o` = 0.
- `hash_v_i` while not in HASH: ignored.

Reset mid-operation: asynchronous return to IDLE; any partial digest is discarded.

## Test plan
- **"abc".** `len_i`=3, `nn_i`=32, bytes 61 62 63, real core with W=32 → bytes 61 62 63 followed by 61×00, first=last=1, `ll_o`=3; `digest_o` = 508C5E8C327C14E2E1A72BA34EEB452F37458B209ED63A294D999B4C86675982 (byte 0 = 50); `done_o` pulses once.
- **Empty message.** `len_i`=0, `nn_i`=32 → 64×00 with first=last=1 and `msg_rdy_o` never high; digest = 69217A3079908094E11121D042354A7C1F55B6482CA1A51E1B250DFD1ED0EEF9.
- **Exact two blocks.** `len_i`=128, model core → block 0 has first=1, last=0; block 1 has first=0, last=1; no padding bytes; `cnt_q` ends at 128.
- **Host stalls and slow core.** `len_i`=65 with random `msg_v_i` gaps and `core_ready_i` forced low for 5 cycles mid-block → byte stream identical to the no-stall case: 65 message bytes, then 63×00; no duplicate or dropped index.
- **Result capture.** Model core emits a burst of `nn`+1=5 valid cycles AA 01 02 03 04 with `nn_i`=4 → `digest_o[31:0]` = 32'h04030201; AA is discarded.
- **Abuse cases.** `start_i` while busy → ignored. `nreset` low mid-FEED → all outputs 0 immediately; a new job after reset hashes correctly.
